// File: rtl/cache_refill_if.sv
// Bus bundle between the cache refill controller and its environment:
// miss request from the cache, word-read bus to memory, fill/critical-word
// return to the cache and completion status.
interface cache_refill_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int TAG_WIDTH    = 16,
  parameter int OFFSET_WIDTH = 2
);
  logic                              miss_req;
  logic [TAG_WIDTH-1:0]              miss_tag;
  logic [OFFSET_WIDTH-1:0]           miss_offset;
  logic                              busy;
  logic                              mem_req_valid;
  logic                              mem_req_ready;
  logic [TAG_WIDTH+OFFSET_WIDTH-1:0] mem_addr;
  logic                              mem_rsp_valid;
  logic [DATA_WIDTH-1:0]             mem_rsp_data;
  logic                              fill_valid;
  logic [TAG_WIDTH-1:0]              fill_tag;
  logic [OFFSET_WIDTH-1:0]           fill_idx;
  logic [DATA_WIDTH-1:0]             fill_data;
  logic                              crit_valid;
  logic [DATA_WIDTH-1:0]             crit_data;
  logic                              fill_done;
  logic [31:0]                       refill_count;

  // Controller side.
  modport master (
    input  miss_req, miss_tag, miss_offset, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output busy, mem_req_valid, mem_addr, fill_valid, fill_tag, fill_idx, fill_data,
           crit_valid, crit_data, fill_done, refill_count
  );

  // Cache / memory side.
  modport slave (
    output miss_req, miss_tag, miss_offset, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  busy, mem_req_valid, mem_addr, fill_valid, fill_tag, fill_idx, fill_data,
           crit_valid, crit_data, fill_done, refill_count
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: on a miss it fetches the BLOCK_SIZE words of
// the missing block one request at a time, writes each word into the cache
// and returns the requested (critical) word early.
// Optional feature: define CRIT_WORD_FIRST_EN to fetch the block starting at
// the requested word (wrapping), so the critical word arrives first.
module cache_refill_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int TAG_WIDTH    = 16,
  parameter int BLOCK_SIZE   = 4,
  parameter int OFFSET_WIDTH = 2
) (
  input logic            clk,
  input logic            reset,
  cache_refill_if.master bus
);

  localparam int CNT_W = OFFSET_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                            state_q, state_d;
  logic [TAG_WIDTH-1:0]              tag_q, tag_d;
  logic [OFFSET_WIDTH-1:0]           off_q, off_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              busy_q, busy_d;
  logic                              mem_req_valid_q, mem_req_valid_d;
  logic [TAG_WIDTH+OFFSET_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                              fill_valid_q, fill_valid_d;
  logic [TAG_WIDTH-1:0]              fill_tag_q, fill_tag_d;
  logic [OFFSET_WIDTH-1:0]           fill_idx_q, fill_idx_d;
  logic [DATA_WIDTH-1:0]             fill_data_q, fill_data_d;
  logic                              crit_valid_q, crit_valid_d;
  logic [DATA_WIDTH-1:0]             crit_data_q, crit_data_d;
  logic                              fill_done_q, fill_done_d;
  logic [31:0]                       refill_count_q, refill_count_d;

  logic [CNT_W-1:0]        cnt_inc;
  logic [OFFSET_WIDTH-1:0] cur_idx;   // word index of the outstanding request
  logic [OFFSET_WIDTH-1:0] nxt_idx;   // word index of the following request
  logic [OFFSET_WIDTH-1:0] first_idx; // word index of the first request of a miss

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Word order within the block; OFFSET_WIDTH-bit arithmetic gives the wrap.
`ifdef CRIT_WORD_FIRST_EN
  assign cur_idx   = off_q + cnt_q[OFFSET_WIDTH-1:0];
  assign nxt_idx   = off_q + cnt_inc[OFFSET_WIDTH-1:0];
  assign first_idx = bus.miss_offset;
`else
  assign cur_idx   = cnt_q[OFFSET_WIDTH-1:0];
  assign nxt_idx   = cnt_inc[OFFSET_WIDTH-1:0];
  assign first_idx = '0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d         = state_q;
    tag_d           = tag_q;
    off_d           = off_q;
    cnt_d           = cnt_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    fill_valid_d    = 1'b0;
    fill_tag_d      = fill_tag_q;
    fill_idx_d      = fill_idx_q;
    fill_data_d     = fill_data_q;
    crit_valid_d    = 1'b0;
    crit_data_d     = crit_data_q;
    fill_done_d     = 1'b0;
    refill_count_d  = refill_count_q;

    case (state_q)
      IDLE: begin
        if (bus.miss_req) begin
          tag_d           = bus.miss_tag;
          off_d           = bus.miss_offset;
          cnt_d           = '0;
          mem_req_valid_d = 1'b1;
          mem_addr_d      = {bus.miss_tag, first_idx};
          state_d         = REQ;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          fill_valid_d = 1'b1;
          fill_tag_d   = tag_q;
          fill_idx_d   = cur_idx;
          fill_data_d  = bus.mem_rsp_data;
          if (cur_idx == off_q) begin
            crit_valid_d = 1'b1;
            crit_data_d  = bus.mem_rsp_data;
          end
          cnt_d = cnt_inc;
          if (cnt_q == CNT_W'(BLOCK_SIZE - 1)) begin
            fill_done_d    = 1'b1;
            refill_count_d = refill_count_q + 32'd1;
            state_d        = DONE;
          end else begin
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {tag_q, nxt_idx};
            state_d         = REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      tag_q           <= '0;
      off_q           <= '0;
      cnt_q           <= '0;
      busy_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      fill_valid_q    <= 1'b0;
      fill_tag_q      <= '0;
      fill_idx_q      <= '0;
      fill_data_q     <= '0;
      crit_valid_q    <= 1'b0;
      crit_data_q     <= '0;
      fill_done_q     <= 1'b0;
      refill_count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q         <= state_d;
      tag_q           <= tag_d;
      off_q           <= off_d;
      cnt_q           <= cnt_d;
      busy_q          <= busy_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      fill_valid_q    <= fill_valid_d;
      fill_tag_q      <= fill_tag_d;
      fill_idx_q      <= fill_idx_d;
      fill_data_q     <= fill_data_d;
      crit_valid_q    <= crit_valid_d;
      crit_data_q     <= crit_data_d;
      fill_done_q     <= fill_done_d;
      refill_count_q  <= refill_count_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.fill_valid    = fill_valid_q;
  assign bus.fill_tag      = fill_tag_q;
  assign bus.fill_idx      = fill_idx_q;
  assign bus.fill_data     = fill_data_q;
  assign bus.crit_valid    = crit_valid_q;
  assign bus.crit_data     = crit_data_q;
  assign bus.fill_done     = fill_done_q;
  assign bus.refill_count  = refill_count_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed vector table, random
// refills against a block-order reference model, and reset / late-response
// corner cases. Follows CRIT_WORD_FIRST_EN the same way as the design.
module tb_cache_refill_ctrl;

  localparam int DW = 16;
  localparam int TW = 16;
  localparam int BS = 4;
  localparam int OW = 2;
  localparam int AW = TW + OW;
`ifdef CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_refill_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .OFFSET_WIDTH(OW)) bus ();

  cache_refill_ctrl #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .BLOCK_SIZE(BS), .OFFSET_WIDTH(OW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Observed traffic
  typedef struct {
    logic [TW-1:0] tag;
    logic [OW-1:0] idx;
    logic [DW-1:0] data;
    logic          crit;
    logic [DW-1:0] crit_data;
  } fill_t;

  fill_t         fills[$];
  logic [AW-1:0] acc_addr[$];
  int            done_cnt   = 0;
  bit            mem_en     = 1'b1;
  int            stall_left = 0;
  bit            stall_seen = 1'b0;
  logic [AW-1:0] stall_addr = '0;
  logic          pend       = 1'b0;
  logic [AW-1:0] pend_addr  = '0;
  int            exp_count  = 0;

  // Memory model (data = address, response one cycle after accept, optional
  // ready stall on the first request) plus output monitor, on the falling edge.
  initial begin : mem_and_mon
    forever begin
      @(negedge clk);
      if (bus.fill_valid) begin
        fill_t f;
        f.tag = bus.fill_tag; f.idx = bus.fill_idx; f.data = bus.fill_data;
        f.crit = bus.crit_valid; f.crit_data = bus.crit_data;
        fills.push_back(f);
      end
      if (bus.fill_done) done_cnt++;
      if (mem_en) begin
        bus.mem_rsp_valid = pend;
        bus.mem_rsp_data  = DW'(pend_addr);
        if (stall_left > 0 && (bus.mem_req_valid || stall_seen)) begin
          bus.mem_req_ready = 1'b0;
          check("stall_valid_held", bus.mem_req_valid, 1);
          check("stall_no_fill", bus.fill_valid, 0);
          if (stall_seen) check("stall_addr_stable", bus.mem_addr, stall_addr);
          else begin stall_seen = 1'b1; stall_addr = bus.mem_addr; end
          stall_left--;
        end else begin
          bus.mem_req_ready = 1'b1;
        end
        pend      = bus.mem_req_valid && bus.mem_req_ready;
        pend_addr = bus.mem_addr;
        if (pend) acc_addr.push_back(bus.mem_addr);
      end else begin
        pend = 1'b0;
      end
    end
  end

  // Reference: i-th word fetched for a miss on (tag, off).
  function automatic logic [AW-1:0] model_addr(input int tag, input int off, input int i);
    int idx;
    idx = CWF ? (off + i) % BS : i;
    return AW'(tag * BS + idx);
  endfunction

  task automatic run_refill(input logic [TW-1:0] tag, input logic [OW-1:0] off,
                            input int stall, input bit busy_miss, input string name);
    int cyc;
    int n_crit;
    fills.delete();
    acc_addr.delete();
    done_cnt   = 0;
    stall_left = stall;
    stall_seen = 1'b0;
    @(negedge clk);
    bus.miss_req = 1'b1; bus.miss_tag = tag; bus.miss_offset = off;
    @(negedge clk);
    bus.miss_req = 1'b0;
    if (busy_miss) begin
      repeat (2) @(negedge clk);
      check($sformatf("%s busy", name), bus.busy, 1);
      bus.miss_req = 1'b1; bus.miss_tag = 16'h0020; bus.miss_offset = 2'd0;
      @(negedge clk);
      bus.miss_req = 1'b0;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    exp_count++;
    check($sformatf("%s done_seen", name), done_cnt, 1);
    check($sformatf("%s n_req", name), acc_addr.size(), BS);
    for (int i = 0; i < BS && i < acc_addr.size(); i++)
      check($sformatf("%s addr%0d", name, i), acc_addr[i], model_addr(tag, off, i));
    check($sformatf("%s n_fill", name), fills.size(), BS);
    n_crit = 0;
    for (int i = 0; i < BS && i < fills.size(); i++) begin
      logic [AW-1:0] a;
      a = model_addr(tag, off, i);
      check($sformatf("%s fill%0d_tag", name, i), fills[i].tag, tag);
      check($sformatf("%s fill%0d_idx", name, i), fills[i].idx, a[OW-1:0]);
      check($sformatf("%s fill%0d_data", name, i), fills[i].data, DW'(a));
      check($sformatf("%s fill%0d_crit", name, i), fills[i].crit, a[OW-1:0] == off);
      if (fills[i].crit) begin
        n_crit++;
        check($sformatf("%s crit_data", name), fills[i].crit_data, DW'(a));
      end
    end
    check($sformatf("%s n_crit", name), n_crit, 1);
    check($sformatf("%s refill_count", name), bus.refill_count, exp_count);
    check($sformatf("%s idle_after", name), bus.busy, 0);
  endtask

  typedef struct {
    logic [TW-1:0] tag;
    logic [OW-1:0] off;
    int            stall;
    bit            busy_miss;
    logic [AW-1:0] exp_first_addr;
    logic [DW-1:0] exp_crit;
    int            exp_count;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc;
    vecs[0] = '{16'h0010, 2'd1, 0, 1'b0, CWF ? 18'h00041 : 18'h00040, 16'h0041, 1};
    vecs[1] = '{16'h0011, 2'd0, 0, 1'b0, 18'h00044, 16'h0044, 2};
    vecs[2] = '{16'h0010, 2'd1, 5, 1'b0, CWF ? 18'h00041 : 18'h00040, 16'h0041, 3};
    vecs[3] = '{16'h0012, 2'd3, 0, 1'b1, CWF ? 18'h0004B : 18'h00048, 16'h004B, 4};

    bus.miss_req = 1'b0; bus.miss_tag = '0; bus.miss_offset = '0;
    bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", bus.busy, 0);
    check("rst mem_req_valid", bus.mem_req_valid, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst fill_valid", bus.fill_valid, 0);
    check("rst fill_tag", bus.fill_tag, 0);
    check("rst fill_idx", bus.fill_idx, 0);
    check("rst fill_data", bus.fill_data, 0);
    check("rst crit_valid", bus.crit_valid, 0);
    check("rst crit_data", bus.crit_data, 0);
    check("rst fill_done", bus.fill_done, 0);
    check("rst refill_count", bus.refill_count, 0);
    reset = 1'b0;

    // Directed vector table
    for (int v = 0; v < 4; v++) begin
      run_refill(vecs[v].tag, vecs[v].off, vecs[v].stall, vecs[v].busy_miss,
                 $sformatf("vec%0d", v));
      if (acc_addr.size() > 0)
        check($sformatf("vec%0d first_addr", v), acc_addr[0], vecs[v].exp_first_addr);
      for (int i = 0; i < fills.size(); i++)
        if (fills[i].crit)
          check($sformatf("vec%0d crit_value", v), fills[i].crit_data, vecs[v].exp_crit);
      check($sformatf("vec%0d count", v), bus.refill_count, vecs[v].exp_count);
    end

    // Random refills
    for (int r = 0; r < 12; r++)
      run_refill(TW'($urandom_range(0, 16'hFFFF)), OW'($urandom_range(0, BS - 1)),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));

    // Reset in WAIT after two fills, then a late response
    fills.delete(); acc_addr.delete(); done_cnt = 0; stall_left = 0; stall_seen = 1'b0;
    @(negedge clk);
    bus.miss_req = 1'b1; bus.miss_tag = 16'h0010; bus.miss_offset = 2'd1;
    @(negedge clk);
    bus.miss_req = 1'b0;
    cyc = 0;
    while (acc_addr.size() < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rstmid third_req_seen", acc_addr.size(), 3);
    check("rstmid two_fills", fills.size(), 2);
    mem_en = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 16'h0043;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rstmid no_new_fill", fills.size(), 2);
    check("rstmid no_done", done_cnt, 0);
    check("rstmid count", bus.refill_count, 0);
    check("rstmid busy", bus.busy, 0);
    check("rstmid mem_req_valid", bus.mem_req_valid, 0);
    mem_en = 1'b1;

    // Refill after the abandoned one counts from zero again
    run_refill(16'h0011, 2'd0, 0, 1'b0, "post_rst");
    check("post_rst count_one", bus.refill_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, word width.
REQ-002 The block SHALL have parameter TAG_WIDTH, default 16, block address width.
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 4, words per block, power of two.
REQ-004 The block SHALL have parameter OFFSET_WIDTH, default 2, log2(BLOCK_SIZE).
REQ-005 The block SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-007 The block SHALL have port miss_req, input, 1, one-cycle miss pulse from cache.
REQ-008 The block SHALL have ports miss_tag (input, TAG_WIDTH) and miss_offset (input, OFFSET_WIDTH), missing block and requested word.
REQ-009 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-010 The block SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1), mem_addr (output, TAG_WIDTH+OFFSET_WIDTH), word read request.
REQ-011 The block SHALL have ports mem_rsp_valid (input, 1), mem_rsp_data (input, DATA_WIDTH), read response.
REQ-012 The block SHALL have ports fill_valid (output, 1), fill_tag (output, TAG_WIDTH), fill_idx (output, OFFSET_WIDTH), fill_data (output, DATA_WIDTH), cache word write.
REQ-013 The block SHALL have ports crit_valid (output, 1), crit_data (output, DATA_WIDTH), requested-word early return.
REQ-014 The block SHALL have ports fill_done (output, 1) and refill_count (output, 32), completion pulse and completed-refill count.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, DONE; all outputs registered.
REQ-016 IDLE: miss_req high SHALL latch miss_tag/miss_offset, set word counter 0, enter REQ next cycle.
REQ-017 miss_req SHALL be ignored whenever busy is high; no queueing.
REQ-018 REQ: mem_req_valid high, mem_addr = {latched tag, current word index}; both SHALL hold stable until mem_req_ready high, then enter WAIT with mem_req_valid low next cycle.
REQ-019 WAIT: mem_rsp_valid high SHALL cause, next cycle, a one-cycle fill_valid pulse with fill_tag = latched tag, fill_idx = current index, fill_data = mem_rsp_data.
REQ-020 mem_rsp_valid SHALL be ignored in IDLE, REQ and DONE.
REQ-021 crit_valid SHALL pulse one cycle, coincident with fill_valid, for the word whose index equals latched miss_offset; crit_data = that word.
REQ-022 After response, word counter SHALL increment; if BLOCK_SIZE words received, enter DONE, else REQ.
REQ-023 Only one memory request SHALL be outstanding at a time.
REQ-024 DONE: fill_done high for exactly one cycle, refill_count increments by 1 (wraps at 2^32-1 to 0), then IDLE.
REQ-025 Word index SHALL be computed modulo BLOCK_SIZE (OFFSET_WIDTH-bit wrap).

Reset
REQ-026 Reset SHALL force IDLE and zero busy, mem_req_valid, mem_addr, fill_valid, fill_tag, fill_idx, fill_data, crit_valid, crit_data, fill_done, refill_count, word counter.
REQ-027 Reset mid-refill SHALL abandon the refill without fill_done or count increment; a late mem_rsp_valid after reset SHALL be ignored.

Configuration
REQ-028 Macro CRIT_WORD_FIRST_EN defined: word index = (miss_offset + counter) mod BLOCK_SIZE, so crit_valid accompanies the first fill_valid.
REQ-029 Macro CRIT_WORD_FIRST_EN undefined: word index = counter (0..BLOCK_SIZE-1); crit_valid accompanies the fill whose index equals miss_offset.

Verification
REQ-030 Memory model returns data = address, ready always 1, response one cycle after accept; miss_tag 0x0010, miss_offset 1, CRIT_WORD_FIRST_EN defined -> mem_addr 0x41, 0x42, 0x43, 0x40; first fill crit_valid with crit_data 0x0041; fill_done once; refill_count 1.
REQ-031 Same stimulus, CRIT_WORD_FIRST_EN undefined -> mem_addr 0x40..0x43; crit_valid on second fill, crit_data 0x0041.
REQ-032 mem_req_ready held low 5 cycles on first request -> mem_addr 0x41 and mem_req_valid stable all 5 cycles; no fill_valid until response.
REQ-033 Second miss_req (tag 0x0020) while busy -> ignored; no 0x80-range address issued; refill_count 1 after fill_done.
REQ-034 reset asserted in WAIT after two fills, then mem_rsp_valid -> no fill_valid, no fill_done, refill_count 0, state IDLE.
REQ-035 Next miss after completed refill, tag 0x0011 offset 0 -> mem_addr 0x44..0x47, refill_count 2.
